// File: rtl/data_mem_controller_pkg.sv
// data_mem_controller_pkg: size/state encodings, timeout default and lane helpers shared by the controller.
package data_mem_controller_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  // Byte offset of the access inside the word; sizes only honour their natural alignment bits.
  function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_BYTE ? a : sz == SZ_HALF ? {a[1], 1'b0} : 2'b00;
  endfunction
  function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_BYTE ? 4'b0001 << a : sz == SZ_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    return sz == SZ_BYTE ? {4{d[7:0]}} : sz == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? a[0] : |a;
  endfunction
endpackage

// File: rtl/data_mem_controller_load_unit.sv
// data_mem_controller_load_unit: sign/zero-extends lane-shifted load data by access size.
module data_mem_controller_load_unit
  import data_mem_controller_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic byte_sign, half_sign;
  assign byte_sign = data_i[7] & ~unsigned_i;
  assign half_sign = data_i[15] & ~unsigned_i;
  assign data_o = size_i == SZ_BYTE ? {{24{byte_sign}}, data_i[7:0]} :
                  size_i == SZ_HALF ? {{16{half_sign}}, data_i[15:0]} : data_i;
endmodule

// File: rtl/data_mem_controller.sv
// data_mem_controller: single-outstanding load/store sequencer for the data-memory bus.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing them.
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        rsp_misaligned_o
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_e      state_q;
  logic        write_q, uns_q, mem_req_q, mem_we_q, rsp_valid_q, rsp_error_q, rsp_mis_q;
  logic [1:0]  size_q, off_q;
  logic [7:0]  cnt_q;
  logic [31:0] mem_addr_q, mem_wdata_q, rsp_rdata_q, ld_shift, ld_ext;
  logic [3:0]  mem_wstrb_q;
  logic        trap_d;
  assign ld_shift = mem_rdata_i >> {off_q, 3'b000};
  data_mem_controller_load_unit u_load (
    .data_i    (ld_shift),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_o    (ld_ext)
  );
`ifdef MISALIGN_TRAP_EN
  assign trap_d = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
  assign trap_d = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      off_q       <= 2'b00;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_mis_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          write_q <= req_write_i;
          uns_q   <= req_unsigned_i;
          size_q  <= req_size_i;
          off_q   <= lane_off(req_size_i, req_addr_i[1:0]);
          if (trap_d) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_mis_q   <= 1'b1;
          end else begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_write_i;
            mem_addr_q  <= {req_addr_i[31:2], 2'b00};
            mem_wdata_q <= lane_wdata(req_size_i, req_wdata_i);
            mem_wstrb_q <= req_write_i ? lane_strb(req_size_i, req_addr_i[1:0]) : 4'b0000;
          end
        end
        S_REQ: if (mem_gnt_i) begin
          state_q   <= S_WAIT;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          cnt_q     <= 8'd0;
        end
        // A response arriving on the expiry cycle still completes the access cleanly.
        S_WAIT: if (mem_rvalid_i) begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= write_q ? 32'd0 : ld_ext;
        end else if (cnt_q == TO_LAST) begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          rsp_mis_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
      endcase
    end
  end
  assign req_ready_o      = state_q == S_IDLE;
  assign mem_req_o        = mem_req_q;
  assign mem_we_o         = mem_we_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign mem_wstrb_o      = mem_wstrb_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_error_o      = rsp_error_q;
  assign rsp_misaligned_o = rsp_mis_q;
endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: directed plus random accesses checked against a byte-lane reference model.
module tb_data_mem_controller;
  localparam int TO = 4;
  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_error, rsp_misaligned;
  logic [31:0] rsp_rdata;
  int          n_cmp = 0, n_err = 0;

  data_mem_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .rsp_misaligned_o(rsp_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic int base_of(input logic [31:0] a, input logic [1:0] sz);
    return (int'(a % 4) / nbytes(sz)) * nbytes(sz);
  endfunction
  function automatic bit trapped(input logic [31:0] a, input logic [1:0] sz);
`ifdef MISALIGN_TRAP_EN
    return (a % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [3:0] m_strb(input bit wr, input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++) s[i] = wr && i >= base_of(a, sz) && i < base_of(a, sz) + nbytes(sz);
    return s;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % nbytes(sz)) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input bit un,
                                         input logic [31:0] rd);
    longint v = 0;
    int n = nbytes(sz);
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(rd[8*(base_of(a, sz) + i) +: 8]);
    if (!un && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    return 32'(v);
  endfunction

  // gd: extra cycles before grant; rd: WAIT cycle index carrying RVALID (>= TO means timeout).
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                        input bit un, input int gd, input int rd, input logic [31:0] rdat);
    bit tmo = rd >= TO;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = un;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    if (trapped(a, sz)) begin
      chk("trap_valid", 32'(rsp_valid), 32'd1);
      chk("trap_mis", 32'(rsp_misaligned), 32'd1);
      chk("trap_rdata", rsp_rdata, 32'd0);
      chk("trap_memreq", 32'(mem_req), 32'd0);
    end else begin
      for (int g = 0; g <= gd; g++) begin
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_we", 32'(mem_we), 32'(wr));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(m_strb(wr, a, sz)));
        if (wr) chk("mem_wdata", mem_wdata, m_wdata(wd, sz));
        chk("no_rsp_req", 32'(rsp_valid), 32'd0);
        mem_gnt = (g == gd);
        mem_rvalid = (g != gd) && ($urandom_range(0, 1) == 1);
        mem_rdata = $urandom;
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      for (int w = 0; w < TO; w++) begin
        chk("no_rsp_wait", 32'(rsp_valid), 32'd0);
        chk("req_low_wait", 32'(mem_req), 32'd0);
        mem_rvalid = (w == rd);
        mem_rdata = rdat;
        @(negedge clk);
        mem_rvalid = 1'b0;
        if (w == rd) break;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_error", 32'(rsp_error), 32'(tmo));
      chk("rsp_mis", 32'(rsp_misaligned), 32'd0);
      chk("rsp_rdata", rsp_rdata, (wr || tmo) ? 32'd0 : m_load(a, sz, un, rdat));
      mem_rvalid = tmo;
    end
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_outs", {mem_req, mem_we, rsp_valid, rsp_error, rsp_misaligned, mem_wstrb}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    access(1'b0, 32'h1003, 32'h0, 2'd0, 1'b0, 0, 0, 32'h80FFFFFF);
    access(1'b0, 32'h1003, 32'h0, 2'd0, 1'b1, 0, 0, 32'h80FFFFFF);
    access(1'b1, 32'h2002, 32'h0000BEEF, 2'd1, 1'b0, 0, 1, 32'h0);
    access(1'b0, 32'h4006, 32'h0, 2'd1, 1'b0, 3, 2, 32'h8001_1234);
    access(1'b0, 32'h5000, 32'h0, 2'd0, 1'b0, 1, TO + 2, 32'hDEADBEEF);
    access(1'b0, 32'h5004, 32'h0, 2'd2, 1'b0, 0, TO - 1, 32'hCAFEF00D);
    access(1'b0, 32'h3001, 32'h0, 2'd2, 1'b0, 0, 0, 32'h12345678);
    access(1'b1, 32'h3003, 32'hA5A5_1122, 2'd1, 1'b0, 0, 0, 32'h0);
    access(1'b0, 32'h3002, 32'h0, 2'd3, 1'b1, 0, 0, 32'h8765_4321);
    // Reset while the bus request is pending must drop MEM_REQ without a clock edge.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h6000; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_req", 32'(mem_req), 32'd0);
    chk("async_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_norsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    // Reset in WAIT: no completion may follow.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h7000; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("wait_rst_outs", {mem_req, rsp_valid, rsp_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("wait_rst_norsp", 32'(rsp_valid), 32'd0);
    chk("wait_rst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 150; i++)
      access(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
